// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: periodic ultrasonic read, GPIO proximity write and SPI display update
module sensor_poll_scheduler #(
  parameter int          POLL_CYC    = 10_000_000,
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter logic [6:0]  HCSR_ADDR   = 7'h60,
  parameter logic [6:0]  GPIO_ADDR   = 7'h70,
  parameter logic [15:0] NEAR_CM     = 16'd20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        i2c_req,
  output logic [6:0]  i2c_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  input  logic [7:0]  i2c_rdata,
  output logic        spi_req,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic [15:0] distance,
  output logic        near,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic        seq_active
);
  localparam int TW = $clog2(POLL_CYC);
  localparam int OW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_GPIO, SPI_HI, SPI_LO, ERR} state_t;
  state_t state, state_nxt, seq_next;
  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] to_cnt;
  logic [7:0] dist_hi;
  logic [15:0] raw, clamped;
  logic tick, issued, i2c_st, spi_st, rd_st, got_done, timeout, nack;
  assign tick       = enable && tick_cnt == TW'(POLL_CYC - 1);
  assign rd_st      = state == RD_HI || state == RD_LO;
  assign i2c_st     = rd_st || state == WR_GPIO;
  assign spi_st     = state == SPI_HI || state == SPI_LO;
  assign i2c_req    = i2c_st && !issued && !i2c_busy;
  assign spi_req    = spi_st && !issued && !spi_busy;
  assign got_done   = issued && (i2c_st ? i2c_done : spi_st && spi_done);
  assign nack       = i2c_st && i2c_ack_err;
  assign timeout    = (i2c_st || spi_st) && to_cnt == OW'(TIMEOUT_CYC - 1);
  assign i2c_addr   = state == WR_GPIO ? GPIO_ADDR : rd_st ? HCSR_ADDR : 7'h00;
  assign i2c_rw     = rd_st;
  assign i2c_wdata  = state == WR_GPIO && near ? 8'hFF : 8'h00;
  assign spi_tx     = state == SPI_HI ? distance[15:8] : state == SPI_LO ? distance[7:0] : 8'h00;
  assign seq_active = state != IDLE;
  assign raw        = {dist_hi, i2c_rdata};
  assign clamped    = raw > 16'd9999 ? 16'd9999 : raw;
  // poll period counter, parked at zero while polling is disabled
  always_ff @(posedge clk or posedge reset)
    if (reset) tick_cnt <= '0;
    else tick_cnt <= (!enable || tick) ? '0 : tick_cnt + 1'b1;
  // next state: a done beats a coincident timeout, NACK aborts the sequence
  always_comb begin
    seq_next  = state == SPI_LO ? IDLE : state_t'(state + 3'd1);
    state_nxt = state == IDLE ? (tick ? RD_HI : IDLE) :
                state == ERR ? IDLE :
                got_done ? (nack ? ERR : seq_next) :
                timeout ? ERR : state;
  end
  // state register plus one-request-per-visit flag and response timer
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      issued <= 1'b0;
      to_cnt <= '0;
    end else begin
      state  <= state_nxt;
      issued <= state_nxt != state ? 1'b0 : issued | i2c_req | spi_req;
      to_cnt <= state_nxt != state ? '0 : (i2c_req || spi_req) ? OW'(1) :
                (i2c_st || spi_st) ? to_cnt + 1'b1 : to_cnt;
    end
  // captured distance bytes and sticky error bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dist_hi  <= '0;
      distance <= '0;
      near     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (state == RD_HI && got_done && !i2c_ack_err) dist_hi <= i2c_rdata;
      if (state == RD_LO && got_done && !i2c_ack_err) begin
        distance <= clamped;
        near     <= clamped < NEAR_CM;
      end
      if (state == SPI_LO && got_done) err <= 1'b0;
      if (state == ERR) begin
        err     <= 1'b1;
        err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
      end
    end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb_sensor_poll_scheduler: directed bench with simple I2C/SPI responder models
module tb_sensor_poll_scheduler;
  localparam int POLL = 250;
  localparam int TO   = 200;
  localparam int LAT  = 10;
  logic clk = 0, reset = 1, enable = 0;
  logic i2c_req, i2c_rw, i2c_busy = 0, i2c_done = 0, i2c_ack_err = 0;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_wdata, i2c_rdata = 0, spi_tx;
  logic spi_req, spi_busy = 0, spi_done = 0;
  logic [15:0] distance;
  logic near, err, seq_active;
  logic [7:0] err_cnt;
  int cyc = 0, errors = 0, checks = 0;
  int i2c_n = 0, spi_n = 0, dup_n = 0, ni, ns, c, r;
  logic [7:0] rd_hi = 8'h00, rd_lo = 8'h0F, gpio_w = 8'h55, spi_prev = 8'h55, spi_last = 8'h55;
  logic nack_lo = 0, i2c_never = 0, spur_spi = 0;

  sensor_poll_scheduler #(.POLL_CYC(POLL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_wdata(i2c_wdata),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err), .i2c_rdata(i2c_rdata),
    .spi_req(spi_req), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_done(spi_done),
    .distance(distance), .near(near), .err(err), .err_cnt(err_cnt), .seq_active(seq_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // responder models: sample requests mid-cycle, answer LAT cycles later
  initial begin
    int i_cd = 0, s_cd = 0;
    logic i_rd = 0, rd_sel = 0;
    forever begin
      @(negedge clk);
      if (i2c_req) begin
        i2c_n++;
        if (i_cd > 0) dup_n++;
        if (!i2c_rw) gpio_w = i2c_wdata;
        if (i2c_rw && i2c_addr != 7'h60) dup_n++;
        if (!i2c_rw && i2c_addr != 7'h70) dup_n++;
        i_rd = i2c_rw;
        i_cd = i2c_never ? 0 : LAT;
      end
      if (spi_req) begin
        spi_n++;
        if (s_cd > 0) dup_n++;
        spi_prev = spi_last;
        spi_last = spi_tx;
        s_cd = LAT;
      end
      @(posedge clk);
      #1;
      i2c_done = 0;
      i2c_ack_err = 0;
      spi_done = spur_spi;
      if (i_cd > 0) begin
        i_cd--;
        if (i_cd == 0) begin
          i2c_done = 1;
          if (i_rd) begin
            i2c_rdata = rd_sel ? rd_lo : rd_hi;
            i2c_ack_err = rd_sel && nack_lo;
            rd_sel = !rd_sel;
          end
        end
      end
      if (s_cd > 0) begin
        s_cd--;
        if (s_cd == 0) spi_done = 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_active(output int cy);
    int n = 0;
    @(negedge clk);
    while (!seq_active && n < 2 * POLL) begin
      @(negedge clk);
      n++;
    end
    if (!seq_active) check("wait_active", seq_active, 1);
    cy = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (seq_active && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("seq_done", seq_active, 0);
  endtask

  initial begin
    logic any;
    int n;
    repeat (3) @(negedge clk);
    check("rst_distance", distance, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_active", seq_active, 0);
    check("rst_i2c_req", i2c_req, 0);
    check("rst_spi_req", spi_req, 0);
    reset = 0;
    enable = 1;
    r = cyc;
    // basic sequence, distance 15
    wait_active(c);
    check("first_req", i2c_req, 1);
    check("first_req_delay", c - r, POLL);
    r = c;
    wait_idle();
    check("t1_i2c_n", i2c_n, 3);
    check("t1_spi_n", spi_n, 2);
    check("t1_spi_hi", spi_prev, 8'h00);
    check("t1_spi_lo", spi_last, 8'h0F);
    check("t1_distance", distance, 15);
    check("t1_near", near, 1);
    check("t1_gpio", gpio_w, 8'hFF);
    // clamp 12345 -> 9999
    rd_hi = 8'h30; rd_lo = 8'h39;
    ni = i2c_n; ns = spi_n;
    wait_active(c);
    check("poll_period", c - r, POLL);
    wait_idle();
    check("t2_distance", distance, 9999);
    check("t2_spi_hi", spi_prev, 8'h27);
    check("t2_spi_lo", spi_last, 8'h0F);
    check("t2_near", near, 0);
    check("t2_gpio", gpio_w, 8'h00);
    check("t2_i2c_n", i2c_n - ni, 3);
    check("t2_spi_n", spi_n - ns, 2);
    // NACK on low byte read
    nack_lo = 1;
    ni = i2c_n; ns = spi_n;
    wait_active(c);
    wait_idle();
    check("t3_err", err, 1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_i2c_n", i2c_n - ni, 2);
    check("t3_spi_n", spi_n - ns, 0);
    check("t3_distance", distance, 9999);
    check("t3_near", near, 0);
    // recovery with 19 cm, just under threshold
    nack_lo = 0; rd_hi = 8'h00; rd_lo = 8'h13;
    wait_active(c);
    wait_idle();
    check("t3b_err", err, 0);
    check("t3b_err_cnt", err_cnt, 1);
    check("t3b_distance", distance, 19);
    check("t3b_near", near, 1);
    check("t3b_gpio", gpio_w, 8'hFF);
    // busy held 50 cycles at RD_HI entry, spurious spi_done, 20 cm exactly
    rd_lo = 8'h14;
    i2c_busy = 1;
    ni = i2c_n; ns = spi_n;
    wait_active(c);
    any = 0;
    for (int k = 0; k < 50; k++) begin
      any |= i2c_req;
      spur_spi = (k == 20);
      if (k < 49) @(negedge clk);
    end
    @(posedge clk);
    #1;
    i2c_busy = 0;
    @(negedge clk);
    check("t5_no_req_busy", any, 0);
    check("t5_req_after_busy", i2c_req, 1);
    check("t5_req_cycle", cyc - c, 50);
    wait_idle();
    check("t5_i2c_n", i2c_n - ni, 3);
    check("t5_spi_n", spi_n - ns, 2);
    check("t5_distance", distance, 20);
    check("t5_near", near, 0);
    check("t5_gpio", gpio_w, 8'h00);
    check("t5_spi_lo", spi_last, 8'h14);
    check("t5_dup", dup_n, 0);
    // reset during SPI_HI
    wait_active(c);
    n = 0;
    while (!spi_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_spi_req", spi_req, 1);
    check("t6_spi_tx", spi_tx, 8'h00);
    #2 reset = 1;
    #1;
    check("t6_rst_distance", distance, 0);
    check("t6_rst_active", seq_active, 0);
    check("t6_rst_spi_req", spi_req, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_near", near, 0);
    @(negedge clk);
    reset = 0;
    r = cyc;
    wait_active(c);
    check("t6_restart_delay", c - r, POLL);
    wait_idle();
    // I2C never answers: timeout and saturating error count
    i2c_never = 1;
    wait_active(c);
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_err", err, 1);
    check("t4_err_cycle", cyc - c, TO + 1);
    check("t4_err_cnt1", err_cnt, 1);
    wait_active(c);
    wait_idle();
    check("t4_err_cnt2", err_cnt, 2);
    repeat (POLL * 256) @(negedge clk);
    check("t4_err_cnt_sat", err_cnt, 255);
    repeat (POLL * 2) @(negedge clk);
    check("t4_err_cnt_hold", err_cnt, 255);
    check("t4_err_sticky", err, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
